ilog2_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fixed-latency pipelined ilog2 unit among NREQ requesters in the chaining datapath.
- Accepts 32-bit operands over valid/ready and issues at most one per cycle to the unit.
- Tracks requester ID and zero-operand status alongside the unit's pipeline, then returns tagged results through a credit-protected output FIFO with backpressure.

---
 rtl/ilog2_rr_sched.sv | 165 ++++++++++++++++
 tb/tb_ilog2_rr_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ilog2_rr_sched.sv
// rtl/ilog2_rr_sched.sv - round-robin scheduler sharing one pipelined ilog2 unit among NREQ requesters
// Optional stall counter output enabled by defining ILOG2_RR_SCHED_STATS_EN.
module ilog2_rr_sched #(
   parameter int NREQ       = 4,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_v,
   output logic [NREQ-1:0]      req_ready,
   output logic [31:0]          lu_v,
   output logic                 lu_issue,
   input  logic [4:0]           lu_log2,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [4:0]           rsp_log2,
   output logic                 rsp_zero
`ifdef ILOG2_RR_SCHED_STATS_EN
   ,
   output logic [31:0]          stat_stall_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = IDW + 6;

   logic [IDW-1:0] rr_ptr;
   logic [CW-1:0]  credits;
   logic           grant;
   logic [IDW-1:0] grant_id;
   logic           found;

   logic [IDW-1:0] lu_id;

   logic [LAT-1:0] tag_vld;
   logic [LAT-1:0] tag_zero;
   logic [IDW-1:0] tag_id [LAT];

   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           push;
   logic           pop;
   logic [EW-1:0]  push_entry;
   logic [EW-1:0]  head;

   // Scan from rr_ptr upward, wrapping; first valid requester wins if a credit is free.
   always_comb begin
      found     = 1'b0;
      grant_id  = '0;
      req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            found    = 1'b1;
            grant_id = IDW'((int'(rr_ptr) + k) % NREQ);
         end
      end
      grant = found && (credits != '0);
      if (grant) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr   <= '0;
         lu_v     <= '0;
         lu_issue <= 1'b0;
         lu_id    <= '0;
      end else begin
         lu_issue <= grant;
         if (grant) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            lu_v   <= req_v[32*grant_id +: 32];
            lu_id  <= grant_id;
         end
      end
   end

   // Each in-flight op holds one credit from grant until its result leaves the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credits <= CW'(FIFO_DEPTH);
      end else if (grant && !pop) begin
         credits <= credits - 1'b1;
      end else if (!grant && pop) begin
         credits <= credits + 1'b1;
      end
   end

   // Tag shift register; its tail lines up with the cycle lu_log2 is valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld  <= '0;
         tag_zero <= '0;
         for (int s = 0; s < LAT; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_vld[0]  <= lu_issue;
         tag_zero[0] <= (lu_v == 32'd0);
         tag_id[0]   <= lu_id;
         for (int s = 1; s < LAT; s++) begin
            tag_vld[s]  <= tag_vld[s-1];
            tag_zero[s] <= tag_zero[s-1];
            tag_id[s]   <= tag_id[s-1];
         end
      end
   end

   assign push       = tag_vld[LAT-1];
   assign push_entry = {tag_id[LAT-1], (tag_zero[LAT-1] ? 5'd0 : lu_log2), tag_zero[LAT-1]};

   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Head fields read as zero while empty so outputs match the reset state.
   assign rsp_id   = rsp_valid ? head[EW-1 -: IDW] : '0;
   assign rsp_log2 = rsp_valid ? head[5:1] : 5'd0;
   assign rsp_zero = rsp_valid ? head[0] : 1'b0;

`ifdef ILOG2_RR_SCHED_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_stall_cnt <= '0;
      end else if ((|req_valid) && (credits == '0) && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
         stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ilog2_rr_sched.sv
// tb/tb_ilog2_rr_sched.sv - scoreboard bench for ilog2_rr_sched with a behavioural ilog2 unit
module tb_ilog2_rr_sched;

   localparam int NREQ = 4;
   localparam int LAT  = 3;
   localparam int FD   = 6;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [32*NREQ-1:0]  req_v;
   logic [NREQ-1:0]     req_ready;
   logic [31:0]         lu_v;
   logic                lu_issue;
   logic [4:0]          lu_log2;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [4:0]          rsp_log2;
   logic                rsp_zero;
`ifdef ILOG2_RR_SCHED_STATS_EN
   logic [31:0]         stat_stall_cnt;
`endif

   logic [31:0] op   [NREQ];
   logic [4:0]  elg  [NREQ];
   logic        ezr  [NREQ];
   logic [4:0]  upipe [LAT];

   logic [IDW+5:0] sb [$];
   int n_vec = 0;
   int n_err = 0;
   int exp_ptr = 0;

   always #5 clk = ~clk;

   assign req_v = {op[3], op[2], op[1], op[0]};

   ilog2_rr_sched #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_v(req_v), .req_ready(req_ready),
      .lu_v(lu_v), .lu_issue(lu_issue), .lu_log2(lu_log2), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_log2(rsp_log2), .rsp_zero(rsp_zero)
`ifdef ILOG2_RR_SCHED_STATS_EN
      , .stat_stall_cnt(stat_stall_cnt)
`endif
   );

   function automatic logic [4:0] flog2(input logic [31:0] v);
      logic [4:0] r;
      r = 5'd31;
      for (int i = 0; i < 32; i++) if (v[i]) r = 5'(i);
      return r;
   endfunction

   // Shared ilog2 unit: LAT register stages; a zero operand yields junk the DUT must mask.
   always @(posedge clk) begin
      upipe[0] <= lu_issue ? flog2(lu_v) : 5'd21;
      for (int s = 1; s < LAT; s++) upipe[s] <= upipe[s-1];
   end
   assign lu_log2 = upipe[LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         check("rsp_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) check("rsp_data", {rsp_id, rsp_log2, rsp_zero}, sb.pop_front());
      end
   end

   // One cycle: check the grant against the modelled pointer and queue the expected result.
   task automatic cycle_obs(output bit acc);
      int cand;
      @(negedge clk);
      acc  = 1'b0;
      cand = -1;
      for (int i = 0; i < NREQ; i++)
         if (cand < 0 && req_valid[(exp_ptr + i) % NREQ]) cand = (exp_ptr + i) % NREQ;
      if (req_ready != '0) begin
         check("grant", req_ready, (cand >= 0) ? (NREQ'(1) << cand) : '0);
         if (cand >= 0) begin
            sb.push_back({IDW'(cand), elg[cand], ezr[cand]});
            exp_ptr = (cand + 1) % NREQ;
            acc = 1'b1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      check("rst_req_ready", req_ready, '0);
      check("rst_lu", {lu_v, lu_issue}, '0);
      check("rst_rsp", {rsp_valid, rsp_id, rsp_log2, rsp_zero}, '0);
      sb.delete();
      exp_ptr = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic set_op(input int i, input logic [31:0] v, input logic [4:0] lg, input logic z);
      op[i] = v; elg[i] = lg; ezr[i] = z;
   endtask

   initial begin
      bit acc;
      int cnt;
      int first;
      logic [31:0] tbl_v  [4];
      logic [4:0]  tbl_lg [4];
      logic        tbl_z  [4];
`ifdef ILOG2_RR_SCHED_STATS_EN
      logic [31:0] st0;
`endif
      tbl_v  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0000_0100};
      tbl_lg = '{5'd0, 5'd0, 5'd31, 5'd8};
      tbl_z  = '{1'b1, 1'b0, 1'b0, 1'b0};
      reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 5'd0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      // Single op from requester 2 with latency check
      rsp_ready = 1'b1;
      set_op(2, 32'h0001_0000, 5'd16, 1'b0);
      req_valid = 4'b0100;
      cycle_obs(acc);
      check("single_acc", 64'(acc), 64'd1);
      req_valid = '0;
      @(negedge clk);
      check("single_issue", {lu_issue, lu_v}, {1'b1, 32'h0001_0000});
      check("single_ready_low", req_ready, '0);
      first = 0;
      for (int n = 2; n <= 8; n++) begin
         @(negedge clk);
         if (n == 2) check("issue_one_cycle", 64'(lu_issue), 64'd0);
         if (rsp_valid && first == 0) first = n;
      end
      check("single_latency", 64'(first), 64'(2 + LAT));
      @(posedge clk); #1;
      drain();

      // Fairness: all valid, rotation 3,0,1,2,... with no bubbles
      set_op(0, 32'h1, 5'd0, 1'b0);
      set_op(1, 32'h80, 5'd7, 1'b0);
      set_op(2, 32'h0002_0000, 5'd17, 1'b0);
      set_op(3, 32'h8000_0000, 5'd31, 1'b0);
      req_valid = 4'b1111;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         cycle_obs(acc);
         cnt += int'(acc);
      end
      check("fair_no_bubble", 64'(cnt), 64'd12);
      drain();

      // Zero and edge operands through requester 1, back to back
      for (int k = 0; k < 4; k++) begin
         set_op(1, tbl_v[k], tbl_lg[k], tbl_z[k]);
         req_valid = 4'b0010;
         acc = 1'b0;
         for (int c = 0; c < 10 && !acc; c++) cycle_obs(acc);
         check("edge_accept", 64'(acc), 64'd1);
      end
      drain();

      // Backpressure: FD accepts then stall; one pop frees one accept
      rsp_ready = 1'b0;
      set_op(1, 32'h0000_0003, 5'd1, 1'b0);
      req_valid = 4'b1111;
`ifdef ILOG2_RR_SCHED_STATS_EN
      st0 = stat_stall_cnt;
`endif
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
         cycle_obs(acc);
         cnt += int'(acc);
      end
      check("bp_accepts", 64'(cnt), 64'(FD));
`ifdef ILOG2_RR_SCHED_STATS_EN
      check("stat_stall", 64'(stat_stall_cnt - st0), 64'(14 - FD));
`endif
      rsp_ready = 1'b1;
      cnt = 0;
      cycle_obs(acc);
      cnt += int'(acc);
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cycle_obs(acc);
         cnt += int'(acc);
      end
      check("bp_one_per_pop", 64'(cnt), 64'd1);
      drain();

      // Reset with three ops in flight; stale results must never appear
      req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) cycle_obs(acc);
      req_valid = '0;
      @(posedge clk); #1;
      pulse_reset();
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         cnt += int'(rsp_valid);
      end
      check("no_stale_rsp", 64'(cnt), 64'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         cycle_obs(acc);
         cnt += int'(acc);
      end
      check("credits_after_reset", 64'(cnt), 64'(FD));
      req_valid = '0;
      pulse_reset();

      // Pointer wrap: 3 then 0, then pointer sits at 1
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      cycle_obs(acc);
      check("wrap_g3", 64'(acc), 64'd1);
      req_valid = 4'b0001;
      cycle_obs(acc);
      check("wrap_g0", 64'(acc), 64'd1);
      req_valid = 4'b1111;
      cycle_obs(acc);
      check("wrap_next", 64'(exp_ptr), 64'd2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
